// File: rtl/pacman_pkg.sv
// Shared encodings for the Pac-Man sprite renderer: facing directions,
// mouth-animation phases, the transparent colour key and the shadow register bundle.
// No logic, no latency; nothing here carries flow control.
package pacman_pkg;

    // Facing direction as driven on the dir input.
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    // Mouth phase; the encoding doubles as the ROM bank select.
    typedef enum logic [1:0] {
        ANIM_CLOSED = 2'd0,
        ANIM_HALF   = 2'd1,
        ANIM_OPEN   = 2'd2,
        ANIM_WIDE   = 2'd3
    } anim_e;

    // A texel of this colour lets the background show through.
    localparam logic [11:0] TRANSPARENT_KEY = 12'h000;

    // Sprite placement sampled once per frame so a frame never tears.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        dir_e       dir;
    } shadow_t;

endpackage

// File: rtl/pacman_sprite_render_if.sv
// Sprite ROM port bundle: texel address plus bank select out, colour back in.
// The ROM answers one cycle after the address (registered address).
// No backpressure: the ROM accepts an address every cycle.
//   rom_row, rom_col : texel address (renderer -> ROM)
//   anim_frame       : mouth-phase bank select (renderer -> ROM mux)
//   rom_color        : texel colour, one cycle after the address (ROM -> renderer)
interface pacman_sprite_render_if;
    import pacman_pkg::*;

    logic [3:0]  rom_row;
    logic [3:0]  rom_col;
    logic [1:0]  anim_frame;
    logic [11:0] rom_color;

    modport master (
        output rom_row,
        output rom_col,
        output anim_frame,
        input  rom_color
    );

    modport slave (
        input  rom_row,
        input  rom_col,
        input  anim_frame,
        output rom_color
    );

endinterface

// File: rtl/pacman_anim_ctrl.sv
// Mouth animation: ping-pong CLOSED/HALF/OPEN/WIDE, one step per ANIM_DIV ticks.
// anim_frame is registered and moves only on a frame_tick edge.
// No backpressure; moving=0 freezes both the tick counter and the phase.
//   clk, reset_n   : pixel clock, synchronous active-low reset
//   frame_tick     : one pulse per frame (start of vertical blanking)
//   moving         : enables counting; 0 holds the animation
//   anim_frame     : current mouth phase (ROM bank select)
module pacman_anim_ctrl
    import pacman_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  frame_tick,
    input  logic  moving,
    output anim_e anim_frame
);

    // The tick counter is 3 bits wide, so ANIM_DIV is limited to 1..8.
    localparam logic [2:0] DIV_LAST = 3'(ANIM_DIV - 1);

    logic [2:0] cnt_q;
    anim_e      state_q;
    logic       opening_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= 3'd0;
            state_q   <= ANIM_CLOSED;
            opening_q <= 1'b1;
        end else if (frame_tick && moving) begin
            if (cnt_q == DIV_LAST) begin
                cnt_q <= 3'd0;
                // Turn around on arriving at either end so the end phases
                // are shown once per sweep rather than twice.
                if (opening_q) begin
                    state_q <= anim_e'(state_q + 2'd1);
                    if (state_q == ANIM_OPEN) begin
                        opening_q <= 1'b0;
                    end
                end else begin
                    state_q <= anim_e'(state_q - 2'd1);
                    if (state_q == ANIM_HALF) begin
                        opening_q <= 1'b1;
                    end
                end
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign anim_frame = state_q;

endmodule

// File: rtl/pacman_sprite_render.sv
// Pac-Man sprite renderer: per-pixel ROM addressing, transparency and compositing.
// Latency 2 cycles pixel inputs -> rgb_out/sprite_on (1 ROM read + 1 output register).
// No backpressure: one pixel accepted and one produced every clock.
//   clk, reset_n         : pixel clock, synchronous active-low reset
//   frame_tick           : frame pulse; samples pos_x/pos_y/dir and advances animation
//   video_on, pixel_x/y  : current raster position and visibility
//   pos_x/y, dir, moving : requested sprite placement, facing and animation enable
//   bg_rgb               : background colour of the current pixel
//   rom                  : sprite ROM address/bank out, colour in
//   rgb_out, sprite_on   : composited colour and opaque-sprite flag
module pacman_sprite_render
    import pacman_pkg::*;
#(
    parameter int SPRITE_SIZE = 10,
    parameter int ANIM_DIV    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_tick,
    input  logic                          video_on,
    input  logic [9:0]                    pixel_x,
    input  logic [9:0]                    pixel_y,
    input  logic [9:0]                    pos_x,
    input  logic [9:0]                    pos_y,
    input  logic [1:0]                    dir,
    input  logic                          moving,
    input  logic [11:0]                   bg_rgb,
    pacman_sprite_render_if.master        rom,
    output logic [11:0]                   rgb_out,
    output logic                          sprite_on
);

    // Sprite addresses are 4 bits, so SPRITE_SIZE is limited to 1..16.
    localparam logic [3:0] N_LAST = 4'(SPRITE_SIZE - 1);

    shadow_t          shadow_q;
    anim_e            anim_frame_w;

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic             hit;
    logic [3:0]       row_d;
    logic [3:0]       col_d;

    logic             hit_d1_q;
    logic [11:0]      bg_d1_q;

    logic [11:0]      rgb_d;
    logic             sprite_on_d;
    logic [11:0]      rgb_q;
    logic             sprite_on_q;

    // Placement is only sampled on the frame pulse so the sprite never
    // splits between two positions within one displayed frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q <= '{x: 10'd0, y: 10'd0, dir: DIR_RIGHT};
        end else if (frame_tick) begin
            shadow_q <= '{x: pos_x, y: pos_y, dir: dir_e'(dir)};
        end
    end

    pacman_anim_ctrl #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .moving     (moving),
        .anim_frame (anim_frame_w)
    );

    // One extra bit keeps the sign, so a pixel left of or above the sprite
    // is negative instead of wrapping into a large positive offset.
    assign dx = $signed({1'b0, pixel_x}) - $signed({1'b0, shadow_q.x});
    assign dy = $signed({1'b0, pixel_y}) - $signed({1'b0, shadow_q.y});

    assign hit = video_on
              && !dx[10] && (dx[9:0] < 10'(SPRITE_SIZE))
              && !dy[10] && (dy[9:0] < 10'(SPRITE_SIZE));

    // The ROM holds the right-facing sprite; other facings are
    // transposes/mirrors of its address.
    always_comb begin
        row_d = 4'd0;
        col_d = 4'd0;
        if (hit) begin
            unique case (shadow_q.dir)
                DIR_RIGHT: begin row_d = dy[3:0];          col_d = dx[3:0];          end
                DIR_LEFT:  begin row_d = dy[3:0];          col_d = N_LAST - dx[3:0]; end
                DIR_UP:    begin row_d = dx[3:0];          col_d = N_LAST - dy[3:0]; end
                DIR_DOWN:  begin row_d = dx[3:0];          col_d = dy[3:0];          end
                default:   begin row_d = 4'd0;             col_d = 4'd0;             end
            endcase
        end
    end

    assign rom.rom_row    = row_d;
    assign rom.rom_col    = col_d;
    assign rom.anim_frame = anim_frame_w;

    // Stage 1: line hit and background up with the ROM read. Blanked pixels
    // carry black so the output is dark outside the visible area.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_d1_q <= 1'b0;
            bg_d1_q  <= 12'h000;
        end else begin
            hit_d1_q <= hit;
            bg_d1_q  <= video_on ? bg_rgb : 12'h000;
        end
    end

    always_comb begin
        rgb_d       = bg_d1_q;
        sprite_on_d = 1'b0;
        if (hit_d1_q && (rom.rom_color != TRANSPARENT_KEY)) begin
            rgb_d       = rom.rom_color;
            sprite_on_d = 1'b1;
        end
    end

    // Stage 2: registered output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_q       <= 12'h000;
            sprite_on_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            sprite_on_q <= sprite_on_d;
        end
    end

    assign rgb_out   = rgb_q;
    assign sprite_on = sprite_on_q;

endmodule

// File: tb/tb_pacman_sprite_render.sv
// Bench for pacman_sprite_render: registered ROM model, reference model and
// output scoreboard; expected pixels queued at drive time, checked 2 cycles later.
// Runs free; every wait is a bounded clock count.
module tb_pacman_sprite_render;
    import pacman_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        video_on;
    logic [9:0]  pixel_x, pixel_y, pos_x, pos_y;
    logic [1:0]  dir;
    logic        moving;
    logic [11:0] bg_rgb;
    logic [11:0] rgb_out;
    logic        sprite_on;

    always #5 clk = ~clk;

    pacman_sprite_render_if rom_if ();

    pacman_sprite_render #(
        .SPRITE_SIZE (10),
        .ANIM_DIV    (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .dir        (dir),
        .moving     (moving),
        .bg_rgb     (bg_rgb),
        .rom        (rom_if),
        .rgb_out    (rgb_out),
        .sprite_on  (sprite_on)
    );

    // ROM model: registered address, optional forced value for key tests.
    logic        rom_ov_en  = 1'b0;
    logic [11:0] rom_ov_val = 12'h000;

    function automatic logic [11:0] rom_pattern(input logic [1:0] f, input logic [3:0] r,
                                                input logic [3:0] c);
        return {2'b10, f, r, c};
    endfunction

    always @(posedge clk) begin
        rom_if.rom_color <= rom_ov_en ? rom_ov_val
                          : rom_pattern(rom_if.anim_frame, rom_if.rom_row, rom_if.rom_col);
    end

    // Reference model state.
    typedef struct packed {
        logic [11:0] rgb;
        logic        son;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  m_px, m_py;
    logic [1:0]  m_dir;
    int          m_cnt, m_idx;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [1:0] anim_of(input int idx);
        case (idx)
            0: return 2'd0;
            1: return 2'd1;
            2: return 2'd2;
            3: return 2'd3;
            4: return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    function automatic void model_reset();
        m_px  = 10'd0;
        m_py  = 10'd0;
        m_dir = 2'd0;
        m_cnt = 0;
        m_idx = 0;
    endfunction

    // One pixel: check the output of the pixel two back, drive this one,
    // check its ROM address, predict its output, apply the frame tick.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic vo,
                        input logic [11:0] bg, input logic tick,
                        input logic ov_en, input logic [11:0] ov_val);
        exp_t        e;
        int          ddx, ddy;
        logic        h;
        logic [3:0]  er, ec;
        logic [11:0] romv;
        @(negedge clk);
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rgb_out !== e.rgb || sprite_on !== e.son) begin
                n_bad++;
                $display("FAIL pixel_out t=%0t: got rgb=%h on=%b, want rgb=%h on=%b",
                         $time, rgb_out, sprite_on, e.rgb, e.son);
            end
        end
        pixel_x    = x;
        pixel_y    = y;
        video_on   = vo;
        bg_rgb     = bg;
        frame_tick = tick;
        rom_ov_en  = ov_en;
        rom_ov_val = ov_val;

        ddx = int'(x) - int'(m_px);
        ddy = int'(y) - int'(m_py);
        h   = vo && ddx >= 0 && ddx < 10 && ddy >= 0 && ddy < 10;
        er  = 4'd0;
        ec  = 4'd0;
        if (h) begin
            case (m_dir)
                2'd0:    begin er = 4'(ddy);     ec = 4'(ddx);     end
                2'd1:    begin er = 4'(ddy);     ec = 4'(9 - ddx); end
                2'd2:    begin er = 4'(ddx);     ec = 4'(9 - ddy); end
                default: begin er = 4'(ddx);     ec = 4'(ddy);     end
            endcase
        end
        romv = ov_en ? ov_val : rom_pattern(anim_of(m_idx), er, ec);
        if (!vo)                    e = {12'h000, 1'b0};
        else if (h && romv != 12'h000) e = {romv, 1'b1};
        else                        e = {bg, 1'b0};
        exp_q.push_back(e);

        #1;
        n_cmp++;
        if (rom_if.rom_row !== er || rom_if.rom_col !== ec) begin
            n_bad++;
            $display("FAIL rom_addr px=(%0d,%0d): got row=%0d col=%0d, want row=%0d col=%0d",
                     x, y, rom_if.rom_row, rom_if.rom_col, er, ec);
        end

        if (tick) begin
            m_px  = pos_x;
            m_py  = pos_y;
            m_dir = dir;
            if (moving) begin
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 6;
                end
            end
        end

        @(posedge clk);
        #1;
        n_cmp++;
        if (rom_if.anim_frame !== anim_of(m_idx)) begin
            n_bad++;
            $display("FAIL anim_frame t=%0t: got %0d, want %0d",
                     $time, rom_if.anim_frame, anim_of(m_idx));
        end
    endtask

    task automatic idle(input logic tick);
        step(10'd0, 10'd0, 1'b0, 12'h000, tick, 1'b0, 12'h000);
    endtask

    task automatic place(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
        pos_x = x;
        pos_y = y;
        dir   = d;
        idle(1'b1);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        moving     = 1'b0;
        pos_x      = 10'd300;
        pos_y      = 10'd200;
        dir        = 2'd1;
        pixel_x    = 10'd2;
        pixel_y    = 10'd5;
        video_on   = 1'b1;
        bg_rgb     = 12'hABC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rgb_out !== 12'h000 || sprite_on !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: got rgb=%h on=%b, want 000/0", rgb_out, sprite_on);
        end
        n_cmp++;
        if (rom_if.anim_frame !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_anim: got %0d, want 0", rom_if.anim_frame);
        end
        // Shadow at (0,0) facing right: pixel (2,5) addresses row 5, col 2.
        n_cmp++;
        if (rom_if.rom_row !== 4'd5 || rom_if.rom_col !== 4'd2) begin
            n_bad++;
            $display("FAIL reset_shadow: got row=%0d col=%0d, want 5/2",
                     rom_if.rom_row, rom_if.rom_col);
        end
        model_reset();
        exp_q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rgb_out !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_release: got rgb=%h, want 000", rgb_out);
        end
    endtask

    task automatic test_capture_right();
        place(10'd100, 10'd50, 2'd0);
        step(10'd103, 10'd52, 1'b1, 12'h111, 1'b0, 1'b0, 12'h000);
        step(10'd100, 10'd50, 1'b1, 12'h111, 1'b0, 1'b0, 12'h000);
        step(10'd109, 10'd59, 1'b1, 12'h111, 1'b0, 1'b0, 12'h000);
        step(10'd110, 10'd50, 1'b1, 12'h222, 1'b0, 1'b0, 12'h000);
        step(10'd99,  10'd50, 1'b1, 12'h333, 1'b0, 1'b0, 12'h000);
        // New request without a tick must not move the sprite.
        pos_x = 10'd400;
        step(10'd103, 10'd52, 1'b1, 12'h111, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_directions();
        place(10'd100, 10'd50, 2'd1);
        step(10'd100, 10'd50, 1'b1, 12'h010, 1'b0, 1'b0, 12'h000);
        step(10'd105, 10'd53, 1'b1, 12'h010, 1'b0, 1'b0, 12'h000);
        place(10'd100, 10'd50, 2'd2);
        step(10'd102, 10'd53, 1'b1, 12'h020, 1'b0, 1'b0, 12'h000);
        place(10'd100, 10'd50, 2'd3);
        step(10'd102, 10'd53, 1'b1, 12'h030, 1'b0, 1'b0, 12'h000);
        // dir changes with a tick in the same cycle: new value applies next.
        pos_x = 10'd100;
        pos_y = 10'd50;
        dir   = 2'd1;
        step(10'd101, 10'd51, 1'b1, 12'h040, 1'b1, 1'b0, 12'h000);
        step(10'd101, 10'd51, 1'b1, 12'h040, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_transparency();
        place(10'd100, 10'd50, 2'd0);
        step(10'd100, 10'd50, 1'b1, 12'h00F, 1'b0, 1'b1, 12'h000);
        step(10'd100, 10'd50, 1'b1, 12'h00F, 1'b0, 1'b1, 12'hFF0);
        step(10'd100, 10'd50, 1'b0, 12'h00F, 1'b0, 1'b1, 12'hFF0);
        step(10'd120, 10'd50, 1'b1, 12'h0F0, 1'b0, 1'b1, 12'hFF0);
    endtask

    task automatic test_clipping();
        place(10'd635, 10'd0, 2'd0);
        step(10'd3,   10'd0, 1'b1, 12'h123, 1'b0, 1'b0, 12'h000);
        step(10'd636, 10'd0, 1'b1, 12'h123, 1'b0, 1'b0, 12'h000);
        place(10'd0, 10'd0, 2'd0);
        step(10'd9,  10'd0, 1'b1, 12'h456, 1'b0, 1'b0, 12'h000);
        step(10'd10, 10'd0, 1'b1, 12'h456, 1'b0, 1'b0, 12'h000);
        step(10'd9,  10'd9, 1'b1, 12'h456, 1'b0, 1'b0, 12'h000);
        step(10'd9, 10'd10, 1'b1, 12'h456, 1'b0, 1'b0, 12'h000);
        step(10'd1023, 10'd0, 1'b1, 12'h456, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_animation();
        moving = 1'b1;
        repeat (56) idle(1'b1);
        moving = 1'b0;
        repeat (20) idle(1'b1);
        step(10'd1, 10'd1, 1'b1, 12'h777, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic [9:0] x, y;
            logic       t;
            t = ($urandom_range(0, 7) == 0);
            if (t) begin
                pos_x  = 10'($urandom_range(0, 630));
                pos_y  = 10'($urandom_range(0, 470));
                dir    = 2'($urandom_range(0, 3));
                moving = 1'($urandom_range(0, 1));
            end
            x = 10'(int'(m_px) + int'($urandom_range(0, 13)) - 2);
            y = 10'(int'(m_py) + int'($urandom_range(0, 13)) - 2);
            step(x, y, 1'($urandom_range(0, 7) != 0), 12'($urandom_range(0, 4095)), t,
                 1'($urandom_range(0, 5) == 0), 12'($urandom_range(0, 1) * 12'hF0F));
        end
        moving = 1'b0;
    endtask

    task automatic test_reset_mid();
        place(10'd100, 10'd50, 2'd0);
        step(10'd103, 10'd52, 1'b1, 12'h0AA, 1'b0, 1'b0, 12'h000);
        step(10'd104, 10'd53, 1'b1, 12'h0AA, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        reset_n  = 1'b0;
        pixel_x  = 10'd3;
        pixel_y  = 10'd4;
        video_on = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rgb_out !== 12'h000 || sprite_on !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_out: got rgb=%h on=%b, want 000/0", rgb_out, sprite_on);
        end
        n_cmp++;
        if (rom_if.anim_frame !== 2'd0) begin
            n_bad++;
            $display("FAIL midreset_anim: got %0d, want 0", rom_if.anim_frame);
        end
        n_cmp++;
        if (rom_if.rom_row !== 4'd4 || rom_if.rom_col !== 4'd3) begin
            n_bad++;
            $display("FAIL midreset_shadow: got row=%0d col=%0d, want 4/3",
                     rom_if.rom_row, rom_if.rom_col);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rgb_out !== 12'h000) begin
            n_bad++;
            $display("FAIL midreset_release: got rgb=%h, want 000", rgb_out);
        end
        step(10'd3, 10'd4, 1'b1, 12'h0BB, 1'b0, 1'b0, 12'h000);
        step(10'd12, 10'd4, 1'b1, 12'h0BB, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        test_reset();
        test_capture_right();
        test_directions();
        test_transparency();
        test_clipping();
        test_animation();
        test_back_to_back();
        test_reset_mid();
        idle(1'b0);
        idle(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
